// File: rtl/slink_tx_framer_pkg.sv
// Shared SLINK framing definitions: FSM state encoding, framing constants and
// the byte-wide CRC-16/CCITT-FALSE step used by both the TX framer and RX checker.
package slink_tx_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_TICK  = 3'd2,
    ST_LEN_H = 3'd3,
    ST_LEN_L = 3'd4,
    ST_PLD   = 3'd5,
    ST_CRC_H = 3'd6,
    ST_CRC_L = 3'd7
  } state_t;

  localparam logic [7:0]  SLINK_SYNC_BYTE = 8'h5A;
  localparam logic [15:0] CRC16_POLY      = 16'h1021;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

  // MSB-first, non-reflected: data bit 7 enters the register first
  function automatic logic [15:0] crc16_next(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/slink_crc16.sv
// Byte-wide CRC-16/CCITT-FALSE accumulator: combinational next value plus the
// running register, with separate init and update enables (init wins).
module slink_crc16
  import slink_tx_framer_pkg::*;
(
  input  logic        clk_125m,
  input  logic        rst_125m,
  input  logic        crc_init,
  input  logic        crc_upd,
  input  logic [7:0]  crc_data,
  output logic [15:0] crc,
  output logic [15:0] crc_next
);

  assign crc_next = crc16_next(crc, crc_data);

  always_ff @(posedge clk_125m) begin
    if (!rst_125m)     crc <= CRC16_INIT;
    else if (crc_init) crc <= CRC16_INIT;
    else if (crc_upd)  crc <= crc_next;
  end

endmodule

// File: rtl/slink_tx_framer.sv
// SLINK transmit framer: wraps upstream payload as SYNC|TICK|LEN|payload|CRC and
// inserts zero-length keepalive frames when the link has been idle too long.
module slink_tx_framer
  import slink_tx_framer_pkg::*;
#(
  parameter logic [15:0] MAX_LEN          = 16'd1024,
  parameter logic [23:0] KEEPALIVE_CYCLES = 24'd125000,
  parameter logic [7:0]  SYNC_BYTE        = SLINK_SYNC_BYTE
) (
  input  logic        clk_125m,
  input  logic        rst_125m,
  input  logic        pkt_req,
  input  logic [15:0] pkt_len,
  output logic        pkt_ack,
  output logic        pkt_rej,
  input  logic [7:0]  pld_data,
  input  logic        pld_vld,
  output logic        pld_rdy,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  output logic        tx_sop,
  output logic        tx_eop,
  input  logic        tx_rdy,
  output logic [7:0]  tick_cnt,
  output logic        keepalive
);

  localparam logic [23:0] IDLE_LAST = KEEPALIVE_CYCLES - 24'd1;

  state_t      state;
  logic [15:0] len_cnt;
  logic [23:0] idle_cnt;
  logic [7:0]  tx_data_r;
  logic        tx_vld_r;
  logic        in_pld;
  logic        xfer;
  logic        crc_upd;
  logic [15:0] crc;
  logic [15:0] crc_next;

  // Payload bytes bypass the output register so PLD runs at one byte per cycle
  assign in_pld  = (state == ST_PLD);
  assign tx_data = in_pld ? pld_data : tx_data_r;
  assign tx_vld  = in_pld ? pld_vld  : tx_vld_r;
  assign pld_rdy = in_pld & tx_rdy;
  assign xfer    = tx_vld & tx_rdy;

  assign crc_upd = xfer && ((state == ST_TICK) || (state == ST_LEN_H) ||
                            (state == ST_LEN_L) || (state == ST_PLD));

  slink_crc16 u_crc (
    .clk_125m (clk_125m),
    .rst_125m (rst_125m),
    .crc_init (state == ST_IDLE),
    .crc_upd  (crc_upd),
    .crc_data (tx_data),
    .crc      (crc),
    .crc_next (crc_next)
  );

  // On each accepted byte the next byte is loaded in the same edge, so the
  // registered header/trailer bytes also stream without bubbles.
  always_ff @(posedge clk_125m) begin
    if (!rst_125m) begin
      state     <= ST_IDLE;
      len_cnt   <= '0;
      idle_cnt  <= '0;
      tx_data_r <= '0;
      tx_vld_r  <= 1'b0;
      tx_sop    <= 1'b0;
      tx_eop    <= 1'b0;
      pkt_ack   <= 1'b0;
      pkt_rej   <= 1'b0;
      tick_cnt  <= '0;
      keepalive <= 1'b0;
    end else begin
      pkt_ack <= 1'b0;
      pkt_rej <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (idle_cnt != IDLE_LAST) idle_cnt <= idle_cnt + 24'd1;
          // pkt_ack gates the request so a held pkt_req is not acked twice
          if (pkt_req && !pkt_ack) begin
            pkt_ack <= 1'b1;
            if (pkt_len > MAX_LEN) begin
              pkt_rej <= 1'b1;
            end else begin
              len_cnt   <= pkt_len;
              keepalive <= 1'b0;
              idle_cnt  <= '0;
              state     <= ST_SYNC;
            end
          end else if (!pkt_req && (idle_cnt == IDLE_LAST)) begin
            len_cnt   <= '0;
            keepalive <= 1'b1;
            idle_cnt  <= '0;
            state     <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (!tx_vld_r) begin
            tx_data_r <= SYNC_BYTE;
            tx_vld_r  <= 1'b1;
            tx_sop    <= 1'b1;
          end else if (tx_rdy) begin
            tx_data_r <= tick_cnt;
            tx_sop    <= 1'b0;
            state     <= ST_TICK;
          end
        end
        ST_TICK: begin
          if (xfer) begin
            tx_data_r <= len_cnt[15:8];
            state     <= ST_LEN_H;
          end
        end
        ST_LEN_H: begin
          if (xfer) begin
            tx_data_r <= len_cnt[7:0];
            state     <= ST_LEN_L;
          end
        end
        ST_LEN_L: begin
          if (xfer) begin
            if (len_cnt != 16'd0) begin
              tx_vld_r <= 1'b0;
              state    <= ST_PLD;
            end else begin
              tx_data_r <= crc_next[15:8];
              state     <= ST_CRC_H;
            end
          end
        end
        ST_PLD: begin
          if (xfer) begin
            len_cnt <= len_cnt - 16'd1;
            if (len_cnt == 16'd1) begin
              tx_data_r <= crc_next[15:8];
              tx_vld_r  <= 1'b1;
              state     <= ST_CRC_H;
            end
          end
        end
        ST_CRC_H: begin
          if (xfer) begin
            tx_data_r <= crc[7:0];
            tx_eop    <= 1'b1;
            state     <= ST_CRC_L;
          end
        end
        ST_CRC_L: begin
          if (xfer) begin
            tx_data_r <= '0;
            tx_vld_r  <= 1'b0;
            tx_eop    <= 1'b0;
            tick_cnt  <= tick_cnt + 8'd1;
            keepalive <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slink_tx_framer.sv
// Self-checking bench for slink_tx_framer: vector table plus scoreboard on the
// framed byte stream, with hand-written keepalive, tick-wrap and reset sequences.
module tb_slink_tx_framer;

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } exp_t;

  typedef struct {
    logic [15:0] len;
    logic [7:0]  first;
    logic [7:0]  step;
    bit          bp;
    bit          rej;
    int          exp_bytes;
  } vec_t;

  logic        clk;
  logic        rst_125m;
  logic        pkt_req;
  logic [15:0] pkt_len;
  logic        pkt_ack;
  logic        pkt_rej;
  logic [7:0]  pld_data;
  logic        pld_vld;
  logic        pld_rdy;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_sop;
  logic        tx_eop;
  logic        tx_rdy;
  logic [7:0]  tick_cnt;
  logic        keepalive;

  logic        ka_rst;
  logic        ka_req;
  logic [15:0] ka_len;
  logic        ka_ack;
  logic        ka_rej;
  logic [7:0]  ka_pld_data;
  logic        ka_pld_vld;
  logic        ka_pld_rdy;
  logic [7:0]  ka_tx_data;
  logic        ka_tx_vld;
  logic        ka_sop;
  logic        ka_eop;
  logic        ka_tx_rdy;
  logic [7:0]  ka_tick;
  logic        ka_keepalive;

  logic        cu_init;
  logic        cu_upd;
  logic [7:0]  cu_data;
  logic [15:0] cu_crc;
  logic [15:0] cu_next;

  int          checks;
  int          errors;
  int          rx_count;
  bit          bp_mode;
  bit          pld_fire;
  bit          stall_prev;
  logic [11:0] held;
  logic [7:0]  tick_model;
  exp_t        mon_e;
  exp_t        exp_q[$];
  logic [7:0]  pld_q[$];
  vec_t        vecs[7];

  slink_tx_framer dut (
    .clk_125m (clk),      .rst_125m (rst_125m),
    .pkt_req  (pkt_req),  .pkt_len  (pkt_len),
    .pkt_ack  (pkt_ack),  .pkt_rej  (pkt_rej),
    .pld_data (pld_data), .pld_vld  (pld_vld),  .pld_rdy (pld_rdy),
    .tx_data  (tx_data),  .tx_vld   (tx_vld),
    .tx_sop   (tx_sop),   .tx_eop   (tx_eop),   .tx_rdy  (tx_rdy),
    .tick_cnt (tick_cnt), .keepalive(keepalive)
  );

  slink_tx_framer #(.KEEPALIVE_CYCLES(24'd16)) dut_ka (
    .clk_125m (clk),         .rst_125m (ka_rst),
    .pkt_req  (ka_req),      .pkt_len  (ka_len),
    .pkt_ack  (ka_ack),      .pkt_rej  (ka_rej),
    .pld_data (ka_pld_data), .pld_vld  (ka_pld_vld), .pld_rdy (ka_pld_rdy),
    .tx_data  (ka_tx_data),  .tx_vld   (ka_tx_vld),
    .tx_sop   (ka_sop),      .tx_eop   (ka_eop),     .tx_rdy  (ka_tx_rdy),
    .tick_cnt (ka_tick),     .keepalive(ka_keepalive)
  );

  slink_crc16 crc_u (
    .clk_125m (clk),     .rst_125m (rst_125m),
    .crc_init (cu_init), .crc_upd  (cu_upd),  .crc_data (cu_data),
    .crc      (cu_crc),  .crc_next (cu_next)
  );

  always #4 clk = ~clk;

  // Reference CRC: byte XORed into the top, then eight shift/reduce steps
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare every accepted byte and the hold-while-stalled rule
  always @(negedge clk) begin
    pld_fire = pld_vld && pld_rdy && rst_125m;
    if (!rst_125m) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) checkOutput("tx_hold", {tx_vld, tx_sop, tx_eop, tx_data}, held);
      if (tx_vld && tx_rdy) begin
        rx_count++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_byte", {tx_sop, tx_eop, tx_data}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("tx_byte", {tx_sop, tx_eop, tx_data}, {mon_e.sop, mon_e.eop, mon_e.data});
        end
      end
      stall_prev = tx_vld && !tx_rdy;
      held       = {tx_vld, tx_sop, tx_eop, tx_data};
    end
  end

  // Payload source and sink readiness; pld_vld is held until accepted
  always @(posedge clk) begin
    #1;
    if (pld_fire && pld_q.size() > 0) void'(pld_q.pop_front());
    if (pld_q.size() == 0) pld_vld = 1'b0;
    else if (!pld_vld || pld_fire) pld_vld = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    pld_data = (pld_q.size() > 0) ? pld_q[0] : 8'h00;
    tx_rdy   = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic pushFrame(input logic [15:0] len, input logic [7:0] first,
                           input logic [7:0] step, input logic [7:0] tick);
    logic [15:0] c;
    logic [7:0]  d;
    c = 16'hFFFF;
    exp_q.push_back('{8'h5A, 1'b1, 1'b0});
    exp_q.push_back('{tick, 1'b0, 1'b0});        c = ref_crc(c, tick);
    exp_q.push_back('{len[15:8], 1'b0, 1'b0});   c = ref_crc(c, len[15:8]);
    exp_q.push_back('{len[7:0], 1'b0, 1'b0});    c = ref_crc(c, len[7:0]);
    for (int i = 0; i < int'(len); i++) begin
      d = first + 8'(i) * step;
      pld_q.push_back(d);
      exp_q.push_back('{d, 1'b0, 1'b0});
      c = ref_crc(c, d);
    end
    exp_q.push_back('{c[15:8], 1'b0, 1'b0});
    exp_q.push_back('{c[7:0], 1'b0, 1'b1});
  endtask

  task automatic requestFrame(input logic [15:0] len, output int lat);
    @(posedge clk); #1;
    pkt_req = 1'b1;
    pkt_len = len;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!pkt_ack && lat < 20);
  endtask

  task automatic applyStimulus(input vec_t v);
    int n;
    int start;
    int seen;
    bp_mode = v.bp;
    start   = rx_count;
    if (!v.rej) begin
      pushFrame(v.len, v.first, v.step, tick_model);
      tick_model = tick_model + 8'd1;
    end
    requestFrame(v.len, n);
    checkOutput("ack_latency", n, 2);
    checkOutput("pkt_rej", pkt_rej, v.rej);
    @(posedge clk); #1;
    pkt_req = 1'b0;
    pkt_len = 16'h0;
    if (!v.rej) begin
      @(negedge clk);
      checkOutput("sop_latency", {tx_vld, tx_sop}, 2'b11);
      n = 0;
      while (exp_q.size() > 0 && n < 5000) begin @(negedge clk); n++; end
    end else begin
      seen = 0;
      repeat (6) begin @(negedge clk); if (tx_vld) seen++; end
      checkOutput("rej_no_tx", seen, 0);
    end
    checkOutput("frame_done", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    checkOutput("frame_bytes", rx_count - start, v.exp_bytes);
    checkOutput("tick_cnt", tick_cnt, tick_model);
    checkOutput("keepalive_data", keepalive, 0);
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst_125m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_125m   = 1'b1;
    tick_model = 8'h00;
  endtask

  task automatic kaFrame(input logic [15:0] len, input logic ka);
    logic [7:0]  b[$];
    logic [15:0] c;
    int          n;
    c = 16'hFFFF;
    b.push_back(8'h5A);
    b.push_back(8'h00);      c = ref_crc(c, 8'h00);
    b.push_back(len[15:8]);  c = ref_crc(c, len[15:8]);
    b.push_back(len[7:0]);   c = ref_crc(c, len[7:0]);
    for (int i = 0; i < int'(len); i++) begin b.push_back(8'hAA); c = ref_crc(c, 8'hAA); end
    b.push_back(c[15:8]);
    b.push_back(c[7:0]);
    for (int i = 0; i < b.size(); i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!ka_tx_vld && n < 50);
      checkOutput("ka_byte", {ka_tx_vld, ka_sop, ka_eop, ka_keepalive, ka_tx_data},
                  {1'b1, i == 0, i == b.size() - 1, ka, b[i]});
      @(posedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    string s;
    int    lat;
    int    waited;

    vecs[0] = '{16'd3,    8'h01, 8'h01, 1'b0, 1'b0, 9};
    vecs[1] = '{16'd3,    8'h01, 8'h01, 1'b1, 1'b0, 9};
    vecs[2] = '{16'd40,   8'h10, 8'h03, 1'b1, 1'b0, 46};
    vecs[3] = '{16'd1025, 8'h00, 8'h01, 1'b0, 1'b1, 0};
    vecs[4] = '{16'd1024, 8'h00, 8'h01, 1'b0, 1'b0, 1030};
    vecs[5] = '{16'd0,    8'h00, 8'h00, 1'b0, 1'b0, 6};
    vecs[6] = '{16'd1,    8'hFF, 8'h00, 1'b1, 1'b0, 7};

    clk = 1'b0; rst_125m = 1'b0; pkt_req = 1'b0; pkt_len = 16'h0;
    pld_data = 8'h00; pld_vld = 1'b0; tx_rdy = 1'b1;
    ka_rst = 1'b0; ka_req = 1'b0; ka_len = 16'h0;
    ka_pld_data = 8'hAA; ka_pld_vld = 1'b1; ka_tx_rdy = 1'b1;
    cu_init = 1'b0; cu_upd = 1'b0; cu_data = 8'h00;
    checks = 0; errors = 0; rx_count = 0; bp_mode = 1'b0; stall_prev = 1'b0;
    tick_model = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state",
                {pkt_ack, pkt_rej, pld_rdy, tx_vld, tx_sop, tx_eop, keepalive, tx_data, tick_cnt}, 0);
    @(posedge clk); #1;
    rst_125m = 1'b1;

    $display("[TB] CRC unit check");
    s = "123456789";
    cu_init = 1'b1;
    @(posedge clk); #1;
    cu_init = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      cu_data = s[i];
      cu_upd  = 1'b1;
      @(posedge clk); #1;
    end
    cu_upd = 1'b0;
    checkOutput("crc_check_value", cu_crc, 16'h29B1);
    cu_data = 8'h00;
    #1;
    checkOutput("crc_next_comb", cu_next, ref_crc(16'h29B1, 8'h00));

    $display("[TB] Vector table");
    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    $display("[TB] Keepalive timing");
    @(posedge clk); #1;
    ka_rst = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("ka_before", ka_keepalive, 0);
    @(posedge clk); #1;
    checkOutput("ka_start", {ka_keepalive, ka_ack}, 2'b10);
    kaFrame(16'd0, 1'b1);
    #1;
    checkOutput("ka_tick", {ka_tick, ka_keepalive}, {8'h01, 1'b0});

    @(posedge clk); #1;
    ka_rst = 1'b0;
    @(posedge clk); #1;
    ka_rst = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    ka_req = 1'b1;
    ka_len = 16'd2;
    @(posedge clk); #1;
    checkOutput("ka_req_wins", {ka_ack, ka_keepalive}, 2'b10);
    ka_req = 1'b0;
    kaFrame(16'd2, 1'b0);

    $display("[TB] Tick wrap");
    doReset();
    for (int i = 0; i < 256; i++) applyStimulus('{16'd0, 8'h00, 8'h00, 1'b0, 1'b0, 6});
    checkOutput("tick_wrapped", tick_cnt, 8'h00);
    applyStimulus('{16'd1, 8'h77, 8'h00, 1'b0, 1'b0, 7});

    $display("[TB] Reset during payload");
    bp_mode = 1'b0;
    pushFrame(16'd8, 8'h30, 8'h01, tick_model);
    requestFrame(16'd8, lat);
    @(posedge clk); #1;
    pkt_req = 1'b0;
    waited = 0;
    while (exp_q.size() > 6 && waited < 100) begin @(negedge clk); waited++; end
    checkOutput("reached_payload", (exp_q.size() <= 6) && (exp_q.size() > 2), 1);
    @(posedge clk); #1;
    rst_125m = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mid_frame", {tx_vld, pld_rdy, tx_sop, tx_eop}, 0);
    exp_q.delete();
    pld_q.delete();
    @(posedge clk); #1;
    rst_125m   = 1'b1;
    tick_model = 8'h00;
    applyStimulus('{16'd2, 8'hC0, 8'h01, 1'b0, 1'b0, 8});

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
